wb_write_arbiter: RTL and testbench

- Writeback-stage writer for the CPU register file's single write port.
- Merges results from two producers: the ALU (single-cycle, no back-pressure) and the memory/load unit (variable latency, valid/ready).
- Serializes both into one registered write per cycle on rf_waddr/rf_wdata/rf_we.
- Buffers colliding load results in a small FIFO and exposes a pending-write lookup for the hazard/stall logic.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 85 ++++++++
 rtl/wb_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the writeback-stage register-file writer.
//   REG_ADDR_W / DATA_W : register address and data widths.
//   wb_entry_t          : one pending register write (addr + data).
//   wb_sel_e            : which source drives the write port next cycle.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO,
    SEL_MEM
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry register-array FIFO holding load results that lost
// arbitration for the register-file write port.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties FIFO)
//   i_push, i_entry : push request and entry to append at the tail
//   i_pop           : pop request (head is discarded, it was read via o_head)
//   o_head          : entry at the head
//   o_full, o_empty : occupancy flags
//   o_count         : occupancy 0..DEPTH
//   o_view          : all slots in age order (index 0 = head, oldest)
//   o_view_valid    : which o_view slots currently hold live entries
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  wb_entry_t        i_entry,
  input  logic             i_pop,
  output wb_entry_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output wb_entry_t        o_view [DEPTH],
  output logic [DEPTH-1:0] o_view_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage has no reset: liveness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Rotate storage into age order so consumers can pick the youngest match
  // simply as the highest-indexed valid hit.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_view
      logic [PTR_W-1:0] w_idx;
      assign w_idx            = r_rd_ptr + PTR_W'(gi);
      assign o_view[gi]       = r_mem[w_idx];
      assign o_view_valid[gi] = (CNT_W'(gi) < r_count);
    end
  endgenerate

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: writeback-stage writer for the register file's single
// write port. Merges ALU results (always accepted) and load results
// (valid/ready) into one registered write per cycle, buffering load results
// that lose arbitration in a small FIFO.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   alu_valid/alu_addr/alu_data       : ALU result, never back-pressured
//   mem_valid/mem_ready/mem_addr/data : load result handshake
//   rf_we/rf_waddr/rf_wdata           : registered register-file write
//   chk_addr/chk_hit                  : pending-write lookup for hazard unit
//   chk_data                          : forwarded value (WB_FWD_EN only)
//   pend_count                        : FIFO occupancy
// Build option: define WB_FWD_EN to add chk_data, the youngest pending value
// for chk_addr (FIFO tail-most match first, then the in-flight write).
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [REG_ADDR_W-1:0] chk_addr,
  output logic                  chk_hit,
`ifdef WB_FWD_EN
  output logic [DATA_W-1:0]     chk_data,
`endif
  output logic [CNT_W-1:0]      pend_count
);

  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0]     r_rf_wdata;

  wb_entry_t        w_head;
  wb_entry_t        w_view [DEPTH];
  logic [DEPTH-1:0] w_view_valid;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;

  wb_sel_e   w_sel;
  logic      w_mem_acc;
  logic      w_mem_ok;
  logic      w_alu_ok;
  logic      w_push;
  logic      w_pop;
  wb_entry_t w_mem_entry;

  // Ready depends only on registered occupancy; a pop in the same cycle does
  // not reopen a full FIFO.
  assign mem_ready = !w_full;
  assign w_mem_acc = mem_valid && mem_ready;

  // Results targeting r0 are dropped outright: they take no write slot and
  // never enter the FIFO, though the load handshake still completes.
  assign w_alu_ok = alu_valid && (alu_addr != '0);
  assign w_mem_ok = w_mem_acc && (mem_addr != '0);

  // A fresh load may only bypass when the FIFO is empty, which keeps loads
  // in acceptance order.
  always_comb begin
    w_sel = SEL_NONE;
    if (w_alu_ok) begin
      w_sel = SEL_ALU;
    end else if (!w_empty) begin
      w_sel = SEL_FIFO;
    end else if (w_mem_ok) begin
      w_sel = SEL_MEM;
    end
  end

  assign w_push      = w_mem_ok && (w_sel != SEL_MEM);
  assign w_pop       = (w_sel == SEL_FIFO);
  assign w_mem_entry = '{addr: mem_addr, data: mem_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_entry      (w_mem_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_view       (w_view),
    .o_view_valid (w_view_valid)
  );

  // Address/data hold their last values on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= (w_sel != SEL_NONE);
      case (w_sel)
        SEL_ALU: begin
          r_rf_waddr <= alu_addr;
          r_rf_wdata <= alu_data;
        end
        SEL_FIFO: begin
          r_rf_waddr <= w_head.addr;
          r_rf_wdata <= w_head.data;
        end
        SEL_MEM: begin
          r_rf_waddr <= mem_addr;
          r_rf_wdata <= mem_data;
        end
        default: ;
      endcase
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign pend_count = w_count;

  // Pending-write lookup.
  logic [DEPTH-1:0] w_fifo_match;
  logic             w_inflight_match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_fifo_match[gi] = w_view_valid[gi] && (w_view[gi].addr == chk_addr);
    end
  endgenerate

  assign w_inflight_match = r_rf_we && (r_rf_waddr == chk_addr);
  assign chk_hit = (chk_addr != '0) && ((|w_fifo_match) || w_inflight_match);

`ifdef WB_FWD_EN
  // Later (younger) matches override earlier ones; the in-flight write is
  // older than anything still queued.
  always_comb begin
    chk_data = '0;
    if (chk_hit) begin
      if (w_inflight_match) chk_data = r_rf_wdata;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_fifo_match[i]) chk_data = w_view[i].data;
      end
    end
  end
`else
  // Entry data is only needed for forwarding.
  logic [DEPTH-1:0] w_unused_view;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_unused
      assign w_unused_view[gi] = ^w_view[gi].data;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_addr;
  logic        chk_hit;
`ifdef WB_FWD_EN
  logic [31:0] chk_data;
`endif
  logic [CNT_W-1:0] pend_count;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .chk_addr   (chk_addr),
    .chk_hit    (chk_hit),
`ifdef WB_FWD_EN
    .chk_data   (chk_data),
`endif
    .pend_count (pend_count)
  );

  int cnt_total = 0;
  int cnt_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cnt_total++;
    if (act !== exp) begin
      cnt_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending loads kept as a plain queue; the write port is a single
  // "last write" record. Results to r0 simply vanish.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  ent_t        m_ent;
  logic        m_we   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_ok   = 1'b0;
  bit          m_acc, m_mem_live, m_alu_live;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      m_acc      = mem_valid && (q.size() != DEPTH);
      m_mem_live = m_acc && (mem_addr != 0);
      m_alu_live = alu_valid && (alu_addr != 0);
      if (m_alu_live) begin
        m_we = 1'b1; m_addr = alu_addr; m_data = alu_data;
        if (m_mem_live) q.push_back('{mem_addr, mem_data});
      end else if (q.size() > 0) begin
        m_ent = q.pop_front();
        m_we = 1'b1; m_addr = m_ent.a; m_data = m_ent.d;
        if (m_mem_live) q.push_back('{mem_addr, mem_data});
      end else if (m_mem_live) begin
        m_we = 1'b1; m_addr = mem_addr; m_data = mem_data;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic        exp_hit;
  logic [31:0] exp_dat;

  always @(negedge clk) begin
    if (m_ok) begin
      check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
      check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
      check("rf_wdata", rf_wdata, m_data);
      check("pend_count", {29'd0, pend_count}, q.size());
      check("mem_ready", {31'd0, mem_ready}, {31'd0, q.size() != DEPTH});
      exp_hit = 1'b0;
      exp_dat = '0;
      if (chk_addr != 0) begin
        if (m_we && m_addr == chk_addr) begin
          exp_hit = 1'b1; exp_dat = m_data;
        end
        foreach (q[i]) begin
          if (q[i].a == chk_addr) begin
            exp_hit = 1'b1; exp_dat = q[i].d;
          end
        end
      end
      check("chk_hit", {31'd0, chk_hit}, {31'd0, exp_hit});
`ifdef WB_FWD_EN
      check("chk_data", chk_data, exp_dat);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  int  k;
  bit  acc;

  initial begin
    rst = 1'b1; alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0; chk_addr = 0;
    repeat (3) cyc();
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pend", {29'd0, pend_count}, 32'd0);
    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    rst = 1'b0;
    cyc();

    // Load only: direct bypass write one cycle later.
    mem_valid = 1; mem_addr = 5; mem_data = 32'hDEADBEEF;
    cyc();
    idle();
    check("load_we", {31'd0, rf_we}, 32'd1);
    check("load_waddr", {27'd0, rf_waddr}, 32'd5);
    check("load_wdata", rf_wdata, 32'hDEADBEEF);
    check("load_pend", {29'd0, pend_count}, 32'd0);
    $display("txn load_only r5=deadbeef");

    // Collision: ALU wins, load queued then drained.
    alu_valid = 1; alu_addr = 3; alu_data = 32'h11;
    mem_valid = 1; mem_addr = 7; mem_data = 32'h22;
    cyc();
    idle();
    chk_addr = 7;
    #1;
    check("coll_waddr0", {27'd0, rf_waddr}, 32'd3);
    check("coll_wdata0", rf_wdata, 32'h11);
    check("coll_pend1", {29'd0, pend_count}, 32'd1);
    check("coll_hit", {31'd0, chk_hit}, 32'd1);
    cyc();
    check("coll_waddr1", {27'd0, rf_waddr}, 32'd7);
    check("coll_wdata1", rf_wdata, 32'h22);
    check("coll_pend0", {29'd0, pend_count}, 32'd0);
    chk_addr = 0;
    $display("txn collision r3=11 then r7=22");

    // Fill: ALU hogs the port for 6 cycles; only 4 loads fit.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_addr = 1; alu_data = c;
      mem_valid = 1; mem_addr = 5'(8 + k); mem_data = 32'hA0 + k;
      acc = mem_ready;
      cyc();
      if (acc) k++;
    end
    idle();
    check("fill_accepts", k, 32'd4);
    check("fill_pend", {29'd0, pend_count}, 32'd4);
    check("fill_ready", {31'd0, mem_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("drain_we", {31'd0, rf_we}, 32'd1);
      check("drain_waddr", {27'd0, rf_waddr}, 32'd8 + i);
      check("drain_wdata", rf_wdata, 32'hA0 + i);
    end
    $display("txn fill r8..r11 drained in order");

    // Register 0 results are dropped.
    alu_valid = 1; alu_addr = 0; alu_data = 32'h55;
    cyc();
    idle();
    check("r0_alu_we", {31'd0, rf_we}, 32'd0);
    mem_valid = 1; mem_addr = 0; mem_data = 32'h66;
    check("r0_mem_ready", {31'd0, mem_ready}, 32'd1);
    cyc();
    idle();
    check("r0_mem_we", {31'd0, rf_we}, 32'd0);
    check("r0_pend", {29'd0, pend_count}, 32'd0);
    $display("txn reg0 alu and load dropped");

    // Reset while three loads are queued.
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_addr = 2; alu_data = 32'h70 + c;
      mem_valid = 1; mem_addr = 5'(12 + c); mem_data = 32'hB0 + c;
      cyc();
    end
    idle();
    check("mid_pend3", {29'd0, pend_count}, 32'd3);
    rst = 1'b1;
    cyc();
    check("mid_rst_pend", {29'd0, pend_count}, 32'd0);
    check("mid_rst_we", {31'd0, rf_we}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mid_no_stale", {31'd0, rf_we}, 32'd0);
    end
    $display("txn reset mid-drain");

`ifdef WB_FWD_EN
    // Forwarding: youngest queued value wins.
    alu_valid = 1; alu_addr = 4; alu_data = 32'h1;
    mem_valid = 1; mem_addr = 9; mem_data = 32'h1234;
    cyc();
    mem_data = 32'h5678;
    cyc();
    idle();
    chk_addr = 9;
    #1;
    check("fwd_hit", {31'd0, chk_hit}, 32'd1);
    check("fwd_data", chk_data, 32'h5678);
    repeat (2) cyc();
    chk_addr = 0;
    $display("txn forward r9=5678");
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_addr  = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 9) < 6);
      mem_addr  = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      chk_addr  = 5'($urandom_range(0, 7));
      cyc();
    end
    rst = 1'b0;
    idle();
    repeat (6) cyc();
    $display("txn random 3000 cycles");

    $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
    $finish;
  end

endmodule
